// File: rtl/mm2im_pkg.sv
// Shared types and constants for the sequencing MM2IM mapper: layer geometry,
// lane-word layout and FSM states.
package mm2im_pkg;

    localparam int LAYER_W = 2;
    localparam int OT_W    = 11;
    localparam int OC_W    = 8;
    localparam int TILE_W  = 6;

    // Lane word for the default geometry: {bank[3:0], addr[9:0]}.
    localparam int DEF_BANK_W = 4;
    localparam int DEF_ADDR_W = 10;
    localparam int OMAP_W     = DEF_BANK_W + DEF_ADDR_W;
    localparam logic [OMAP_W-1:0] OMAP_INVALID = '1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_EMIT,
        S_FIN
    } state_t;

    typedef struct packed {
        logic [OT_W-1:0] out_time;
        logic [OC_W-1:0] out_ch;
    } layer_cfg_t;

    function automatic layer_cfg_t layer_cfg(input logic [LAYER_W-1:0] layer);
        layer_cfg_t cfg;
        case (layer)
            2'd0:    cfg = '{out_time: 11'd64,  out_ch: 8'd128};
            2'd1:    cfg = '{out_time: 11'd128, out_ch: 8'd64};
            2'd2:    cfg = '{out_time: 11'd256, out_ch: 8'd32};
            default: cfg = '{out_time: 11'd512, out_ch: 8'd16};
        endcase
        return cfg;
    endfunction

endpackage

// File: rtl/mm2im_lane_calc.sv
// Combinational lane mapper: for one PE lane, derives channel/time, validity and
// the {bank, addr} word in the output BRAM.
module mm2im_lane_calc
    import mm2im_pkg::*;
#(
    parameter int PE_IDX      = 0,
    parameter int K_TAPS      = 4,
    parameter int CH_PER_TILE = 4,
    parameter int STRIDE      = 2,
    parameter int PAD         = 1,
    parameter int NUM_BANKS   = 16,
    parameter int ADDR_W      = 10,
    parameter int ROW_W       = 9
) (
    input  logic [ROW_W-1:0]                        row,
    input  logic [TILE_W-1:0]                       tile,
    input  layer_cfg_t                              cfg,
    output logic                                    lane_valid,
    output logic [$clog2(NUM_BANKS)+ADDR_W-1:0]     lane_omap
);

    localparam int CW     = 16;
    localparam int BANK_W = $clog2(NUM_BANKS);

    logic signed [CW-1:0] chan;
    logic signed [CW-1:0] t;
    logic signed [CW-1:0] page;
    logic [ADDR_W-1:0]    addr;

    // Time can go negative at the top edge (row 0 minus padding), so all of
    // this is signed and the sign bit doubles as the lower-bound test.
    always_comb begin
        chan = signed'(CW'(tile)) * signed'(CW'(CH_PER_TILE)) + signed'(CW'(PE_IDX / K_TAPS));
        t    = signed'(CW'(row)) * signed'(CW'(STRIDE)) - signed'(CW'(PAD))
             + signed'(CW'(PE_IDX % K_TAPS));
        page = chan >>> BANK_W;
        addr = ADDR_W'(page * signed'(CW'(cfg.out_time)) + t);
        lane_valid = (chan < signed'(CW'(cfg.out_ch))) && !t[CW-1]
                  && (t < signed'(CW'(cfg.out_time)));
        lane_omap  = lane_valid ? {chan[BANK_W-1:0], addr} : '1;
    end

endmodule

// File: rtl/mm2im_mapper_seq.sv
// Sequencing MM2IM mapper: walks every output-channel tile of one input row and
// streams a lane mask plus per-lane {bank, addr} per tile. MM2IM_STALL_CNT_EN adds stall_cnt.
module mm2im_mapper_seq
    import mm2im_pkg::*;
#(
    parameter int NUM_PE    = 16,
    parameter int K_TAPS    = 4,
    parameter int STRIDE    = 2,
    parameter int PAD       = 1,
    parameter int NUM_BANKS = 16,
    parameter int ADDR_W    = 10,
    parameter int ROW_W     = 9
) (
    input  logic                                            clk,
    input  logic                                            rst_n,
    input  logic                                            start,
    input  logic [ROW_W-1:0]                                row_id,
    input  logic [1:0]                                      layer_id,
    output logic                                            busy,
    output logic                                            out_valid,
    input  logic                                            out_ready,
    output logic [NUM_PE-1:0]                               cmap,
    output logic [NUM_PE*($clog2(NUM_BANKS)+ADDR_W)-1:0]    omap_flat,
    output logic [5:0]                                      tile_idx,
    output logic                                            last,
`ifdef MM2IM_STALL_CNT_EN
    output logic [15:0]                                     stall_cnt,
`endif
    output logic                                            done
);

    localparam int LANE_W      = $clog2(NUM_BANKS) + ADDR_W;
    localparam int CH_PER_TILE = NUM_PE / K_TAPS;

    state_t                    state, state_nx;
    logic [ROW_W-1:0]          row_q;
    logic [LAYER_W-1:0]        layer_q;
    logic [TILE_W-1:0]         tile_q;
    layer_cfg_t                cfg;
    logic [TILE_W-1:0]         tile_last;
    logic [NUM_PE-1:0]         lane_valid;
    logic [NUM_PE*LANE_W-1:0]  lane_omap;
    logic [NUM_PE-1:0]         cmap_q;
    logic [NUM_PE*LANE_W-1:0]  omap_q;
    logic [TILE_W-1:0]         tile_idx_q;
    logic                      last_q;
    logic                      accept;
    logic                      handshake;
    logic                      final_beat;

    assign cfg        = layer_cfg(layer_q);
    assign tile_last  = TILE_W'(cfg.out_ch / OC_W'(CH_PER_TILE) - OC_W'(1));
    assign accept     = (state == S_IDLE) && start;
    assign handshake  = (state == S_EMIT) && out_ready;
    assign final_beat = (tile_q == tile_last);

    // NOTE: state is updated with non-blocking assignments under an async
    // active-low reset so every flop samples the pre-edge values together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nx;
    end

    // NOTE: the default assignment up front keeps this block free of latches.
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: if (start)     state_nx = S_CALC;
            S_CALC:                state_nx = S_EMIT;
            S_EMIT: if (out_ready) state_nx = final_beat ? S_FIN : S_CALC;
            S_FIN:                 state_nx = S_IDLE;
            default:               state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        busy      = (state == S_CALC) || (state == S_EMIT);
        out_valid = (state == S_EMIT);
        done      = (state == S_FIN);
        last      = last_q && (state == S_EMIT);
    end

    // Job context and the registered beat; the beat only changes in CALC, so
    // it stays stable for the whole EMIT phase however long out_ready stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_q      <= '0;
            layer_q    <= '0;
            tile_q     <= '0;
            cmap_q     <= '0;
            omap_q     <= '1;
            tile_idx_q <= '0;
            last_q     <= 1'b0;
        end else begin
            if (accept) begin
                row_q   <= row_id;
                layer_q <= layer_id;
                tile_q  <= '0;
            end else if (handshake && !final_beat) begin
                tile_q  <= tile_q + TILE_W'(1);
            end
            if (state == S_CALC) begin
                cmap_q     <= lane_valid;
                omap_q     <= lane_omap;
                tile_idx_q <= tile_q;
                last_q     <= final_beat;
            end
        end
    end

    assign cmap      = cmap_q;
    assign omap_flat = omap_q;
    assign tile_idx  = tile_idx_q;

    for (genvar g = 0; g < NUM_PE; g++) begin : g_lane
        mm2im_lane_calc #(
            .PE_IDX      (g),
            .K_TAPS      (K_TAPS),
            .CH_PER_TILE (CH_PER_TILE),
            .STRIDE      (STRIDE),
            .PAD         (PAD),
            .NUM_BANKS   (NUM_BANKS),
            .ADDR_W      (ADDR_W),
            .ROW_W       (ROW_W)
        ) u_lane (
            .row        (row_q),
            .tile       (tile_q),
            .cfg        (cfg),
            .lane_valid (lane_valid[g]),
            .lane_omap  (lane_omap[g*LANE_W +: LANE_W])
        );
    end

`ifdef MM2IM_STALL_CNT_EN
    logic [15:0] stall_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                         stall_q <= '0;
        else if (accept)                                    stall_q <= '0;
        else if (out_valid && !out_ready && stall_q != '1)  stall_q <= stall_q + 16'd1;
    end

    assign stall_cnt = stall_q;
`endif

endmodule

// File: doc/mm2im_mapper_seq.md
Name: mm2im_mapper_seq

Overview:
Sequencing successor to the single-shot MM2IM mapper for transposed convolution.
- Given one input row and a layer, it walks every output-channel tile on its own. For each tile it emits a PE lane mask (cmap) and per-lane output BRAM bank/address (omap) on a valid/ready stream.
- Stride, pad, kernel taps, PE count and bank count are parameters.
- Sits between the transposed-conv controller and the PE-array writeback/accumulate path.

Parameters:
- NUM_PE, 16, number of PE lanes; must be a multiple of K_TAPS.
- K_TAPS, 4, kernel taps per channel; lane k = pe % K_TAPS.
- STRIDE, 2, transposed-conv stride.
- PAD, 1, transposed-conv padding.
- NUM_BANKS, 16, output BRAM banks; power of 2.
- ADDR_W, 10, BRAM address width.
- ROW_W, 9, row_id width.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request a row job; accepted only in IDLE
- row_id  in  ROW_W  input row index
- layer_id  in  2  0=d1, 1=d2, 2=d3, 3=d4
- busy  out  1  high from accept until done
- out_valid  out  1  map beat valid
- out_ready  in  1  downstream accepts beat
- cmap  out  NUM_PE  lane valid mask
- omap_flat  out  NUM_PE*(log2(NUM_BANKS)+ADDR_W)  per lane {bank, addr}, lane 0 at LSB
- tile_idx  out  6  tile of current beat
- last  out  1  current beat is final tile
- done  out  1  one-cycle pulse after last beat handshake

Behaviour:
- Reset values: busy=0, out_valid=0, cmap=0, every omap lane all-ones, tile_idx=0, last=0, done=0. Reset mid-job aborts; the block returns to IDLE with no done pulse.
- Layer table (out_time/out_ch): d1 64/128, d2 128/64, d3 256/32, d4 512/16.
- CH_PER_TILE = NUM_PE/K_TAPS; tile_max = out_ch/CH_PER_TILE. Defaults give 32/16/8/4.
- FSM states:
  - IDLE: on start, latch row_id/layer_id, set tile=0, go to CALC. start while busy is ignored.
  - CALC: compute and register the beat for the current tile, then go to EMIT.
  - EMIT: hold out_valid with all outputs stable until out_ready.
    - On handshake with tile<tile_max-1: tile++, go to CALC.
    - On handshake of the last tile: go to FIN.
  - FIN: pulse done for one cycle, go to IDLE.
- Lane math (signed, 12-bit minimum):
  - channel = tile*CH_PER_TILE + pe/K_TAPS
  - time = row*STRIDE - PAD + pe%K_TAPS
  - valid = channel<out_ch && 0<=time<out_time
  - bank = channel % NUM_BANKS; page = channel / NUM_BANKS
  - addr = page*out_time + time, truncated to ADDR_W
  - Invalid lane: cmap bit 0, omap lane all-ones.
- Latency: start accepted at cycle 0 → out_valid at cycle 2. Each subsequent beat follows its handshake by 2 cycles.
- last is high only with out_valid on tile tile_max-1.
- busy drops in the same cycle done pulses.

Optional Feature:
MM2IM_STALL_CNT_EN.
- Defined: adds output stall_cnt[15:0]. It counts EMIT cycles with out_valid && !out_ready, saturates at 0xFFFF, and clears on job accept and on reset.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Package mm2im_pkg holds:
  - layer table constants (out_time, out_ch per layer_id)
  - OMAP_W, the lane-word width
  - the invalid-lane sentinel
  - an FSM state enum
- Natural sub-module mm2im_lane_calc: combinational per-lane channel/time/valid/bank/addr, instantiated NUM_PE times inside a generate.

Test Plan:
- Layer 0, row 0, ready always 1 → 32 beats, tile_idx 0..31, last only on beat 31, done one cycle after.
  - Beat 0: cmap=0xEEEE; lane1=0x0000, lane2=0x0001, lane3=0x0002, lane5=0x0400; lane0 all-ones.
- Layer 0, row 10, tile 5 → lane0 = {bank 4, addr 64+19=83} = 0x1053; cmap=0xFFFF.
- Layer 3, row 255 → 4 beats; cmap=0x7777 (time 512 invalid); lane0 of tile 0 addr=509.
- out_ready held low 5 cycles on beat 2 → cmap/omap/tile_idx stable throughout, no beat lost; with MM2IM_STALL_CNT_EN, stall_cnt=5 at done.
- start pulsed while busy, and rst_n asserted mid-job at tile 3 → extra start ignored; after reset all outputs return to reset values, no done pulse, and the next start begins at tile 0.
